bin_to_bcd4: RTL and testbench

BIN_TO_BCD4 -- requirements
Module: bin_to_bcd4

---
 rtl/ssd_utils_pkg.sv | 15 +
 rtl/bcd_add3.sv | 12 +
 rtl/bin_to_bcd4.sv | 126 ++++++++++++
 tb/tb_bin_to_bcd4.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_utils_pkg.sv
// rtl/ssd_utils_pkg.sv - shared SSD utilities constants (state encodings, widths, limits)
package ssd_utils_pkg;

  // Width of the unsigned binary value handed to the converter.
  localparam int BIN_W   = 14;
  // Largest value a 4-digit display can show; larger inputs saturate.
  localparam int BCD_MAX = 9999;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_t;

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble nibble correction, adds 3 to nibbles >= 5
// Ports:
//   nibble   - one BCD digit of the accumulator before the shift
//   adjusted - nibble + 3 when nibble >= 5, otherwise nibble unchanged
module bcd_add3 (
  input  logic [3:0] nibble,
  output logic [3:0] adjusted
);

  assign adjusted = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;

endmodule

// File: rtl/bin_to_bcd4.sv
// rtl/bin_to_bcd4.sv - sequential 14-bit binary to 4-digit BCD converter for an SSD controller
// Ports:
//   clk      - single clock, rising edge
//   rst      - asynchronous active-low reset
//   start    - convert request, sampled only while idle
//   bin      - unsigned value, captured on the accepted start edge
//   busy     - high while converting (CONV and DONE)
//   done     - one-cycle pulse on the cycle the result is updated
//   overflow - last captured value exceeded 9999 (digits saturate at 9999)
//   digit3..digit0 - registered BCD thousands, hundreds, tens, units
//   mode     - per-digit display enable, bit i enables digit i
module bin_to_bcd4
  import ssd_utils_pkg::*;
#(
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [3:0]       digit3,
  output logic [3:0]       digit2,
  output logic [3:0]       digit1,
  output logic [3:0]       digit0,
  output logic [3:0]       mode
);

  localparam int SR_W = 16 + BIN_W;
  localparam logic [BIN_W-1:0] BCD_MAX_W = BIN_W'(BCD_MAX);
  localparam logic [3:0] CNT_INIT = 4'(BIN_W - 1);

  conv_state_t       state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;       // {bcd[15:0], bin_shift[13:0]}
  logic [3:0]        cnt_q, cnt_d;
  logic              ovf_pend_q;       // captured value > 9999
  logic [15:0]       digits_q;
  logic              overflow_q;
  logic              done_q;

  logic [15:0]       bcd_adj;
  logic [SR_W-1:0]   sr_shift;
  logic              last_shift;
  logic              unused_carry;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_add3
      bcd_add3 u_add3 (
        .nibble   (sr_q[BIN_W + 4*g +: 4]),
        .adjusted (bcd_adj[4*g +: 4])
      );
    end
  endgenerate

  // The adjusted thousands MSB falls off the 16-bit accumulator; it only
  // carries weight for values >= 10000, which are handled by saturation.
  assign unused_carry = bcd_adj[15];
  assign sr_shift     = {bcd_adj[14:0], sr_q[BIN_W-1:0], 1'b0};
  assign last_shift   = (state_q == CONV) && (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = {16'd0, bin};
          cnt_d   = CNT_INIT;
          state_d = CONV;
        end
      end
      CONV: begin
        sr_d  = sr_shift;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      digits_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      done_q  <= last_shift;
      if (state_q == IDLE && start) ovf_pend_q <= (bin > BCD_MAX_W);
      // Result is taken from the 14th shift directly so it lands on the
      // same edge that raises done; otherwise the digits hold.
      if (last_shift) begin
        digits_q   <= ovf_pend_q ? 16'h9999 : sr_shift[SR_W-1 -: 16];
        overflow_q <= ovf_pend_q;
      end
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign overflow = overflow_q;
  assign digit3   = digits_q[15:12];
  assign digit2   = digits_q[11:8];
  assign digit1   = digits_q[7:4];
  assign digit0   = digits_q[3:0];

  generate
    if (BLANK_LZ) begin : g_blank
      assign mode = {|digits_q[15:12], |digits_q[15:8], |digits_q[15:4], 1'b1};
    end else begin : g_no_blank
      assign mode = 4'b1111;
    end
  endgenerate

endmodule

// File: tb/tb_bin_to_bcd4.sv
// tb/tb_bin_to_bcd4.sv - self-checking bench for bin_to_bcd4
module tb_bin_to_bcd4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [13:0] bin = '0;

  logic       busy, done, overflow;
  logic [3:0] digit3, digit2, digit1, digit0, mode;
  logic       nb_busy, nb_done, nb_overflow;
  logic [3:0] nb_digit3, nb_digit2, nb_digit1, nb_digit0, nb_mode;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bin_to_bcd4 #(.BLANK_LZ(1'b1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .overflow(overflow),
    .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
    .mode(mode)
  );

  bin_to_bcd4 #(.BLANK_LZ(1'b0)) u_dut_nb (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(nb_busy), .done(nb_done), .overflow(nb_overflow),
    .digit3(nb_digit3), .digit2(nb_digit2), .digit1(nb_digit1), .digit0(nb_digit0),
    .mode(nb_mode)
  );

  function automatic logic [15:0] ref_digits(input int v);
    int s;
    s = (v > 9999) ? 9999 : v;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic logic [3:0] ref_mode(input logic [15:0] d);
    return {d[15:12] != 4'd0, d[15:8] != 8'd0, d[15:4] != 12'd0, 1'b1};
  endfunction

  // Pulses start for one edge, then waits (bounded) for done; lat is the
  // number of edges after the sampling edge, -1 on timeout.
  task automatic run_conv(input logic [13:0] v, output int lat);
    int i;
    @(posedge clk); #1;
    start = 1'b1;
    bin   = v;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    i = 1;
    while (lat < 0 && i <= 40) begin
      @(posedge clk); #1;
      if (done) lat = i;
      i++;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({busy, done, overflow} !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 000", {busy, done, overflow});
    end
    tests++;
    if ({digit3, digit2, digit1, digit0, mode} !== 20'h0000_1) begin
      fails++;
      $display("FAIL reset_digits_mode: got %h expected 00001", {digit3, digit2, digit1, digit0, mode});
    end
    tests++;
    if (nb_mode !== 4'b1111) begin
      fails++;
      $display("FAIL reset_nb_mode: got %b expected 1111", nb_mode);
    end
    rst = 1'b1;
  endtask

  task automatic test_zero;
    int lat;
    run_conv(14'd0, lat);
    tests++;
    if (lat != 14) begin
      fails++;
      $display("FAIL zero_latency: got %0d expected 14", lat);
    end
    tests++;
    if ({digit3, digit2, digit1, digit0, mode, overflow, busy} !== {16'h0000, 4'b0001, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL zero_result: got %h %b ovf=%b busy=%b expected 0000 0001 ovf=0 busy=1",
               {digit3, digit2, digit1, digit0}, mode, overflow, busy);
    end
  endtask

  task automatic test_digits;
    int lat;
    run_conv(14'd1234, lat);
    tests++;
    if ({digit3, digit2, digit1, digit0, mode} !== {16'h1234, 4'b1111} || lat != 14) begin
      fails++;
      $display("FAIL digits_1234: got %h mode=%b lat=%0d expected 1234 mode=1111 lat=14",
               {digit3, digit2, digit1, digit0}, mode, lat);
    end
    run_conv(14'd907, lat);
    tests++;
    if ({digit3, digit2, digit1, digit0, mode} !== {16'h0907, 4'b0111}) begin
      fails++;
      $display("FAIL digits_907: got %h mode=%b expected 0907 mode=0111",
               {digit3, digit2, digit1, digit0}, mode);
    end
    run_conv(14'd5, lat);
    tests++;
    if ({digit3, digit2, digit1, digit0, mode} !== {16'h0005, 4'b0001}) begin
      fails++;
      $display("FAIL digits_5: got %h mode=%b expected 0005 mode=0001",
               {digit3, digit2, digit1, digit0}, mode);
    end
  endtask

  task automatic test_overflow;
    int lat;
    run_conv(14'd16383, lat);
    tests++;
    if ({digit3, digit2, digit1, digit0, overflow} !== {16'h9999, 1'b1}) begin
      fails++;
      $display("FAIL overflow_16383: got %h ovf=%b expected 9999 ovf=1",
               {digit3, digit2, digit1, digit0}, overflow);
    end
    run_conv(14'd42, lat);
    tests++;
    if ({digit3, digit2, digit1, digit0, overflow, mode} !== {16'h0042, 1'b0, 4'b0011}) begin
      fails++;
      $display("FAIL overflow_clear_42: got %h ovf=%b mode=%b expected 0042 ovf=0 mode=0011",
               {digit3, digit2, digit1, digit0}, overflow, mode);
    end
  endtask

  task automatic test_blank_off;
    int lat;
    run_conv(14'd7, lat);
    tests++;
    if ({nb_digit3, nb_digit2, nb_digit1, nb_digit0, nb_mode} !== {16'h0007, 4'b1111}) begin
      fails++;
      $display("FAIL blank_off_7: got %h mode=%b expected 0007 mode=1111",
               {nb_digit3, nb_digit2, nb_digit1, nb_digit0}, nb_mode);
    end
    tests++;
    if (mode !== 4'b0001) begin
      fails++;
      $display("FAIL blank_on_7: got mode=%b expected 0001", mode);
    end
  endtask

  task automatic test_ignore_start;
    int pulses;
    @(posedge clk); #1;
    start = 1'b1;
    bin   = 14'd1111;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (done) pulses++;
      if (c == 4) begin
        start = 1'b1;
        bin   = 14'd2222;
        tests++;
        if ({busy, digit3, digit2, digit1, digit0} !== {1'b1, 16'h0007}) begin
          fails++;
          $display("FAIL ignore_hold: got busy=%b %h expected busy=1 0007",
                   busy, {digit3, digit2, digit1, digit0});
        end
      end
      if (c == 5) start = 1'b0;
    end
    tests++;
    if (pulses != 1 || {digit3, digit2, digit1, digit0} !== 16'h1111) begin
      fails++;
      $display("FAIL ignore_start: got pulses=%0d %h expected pulses=1 1111",
               pulses, {digit3, digit2, digit1, digit0});
    end
  endtask

  task automatic test_reset_mid;
    int pulses, lat;
    @(posedge clk); #1;
    start = 1'b1;
    bin   = 14'd9999;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    tests++;
    if ({busy, done, overflow, digit3, digit2, digit1, digit0, mode} !== {3'b000, 16'h0000, 4'b0001}) begin
      fails++;
      $display("FAIL reset_mid_async: got busy=%b done=%b ovf=%b %h mode=%b expected 0 0 0 0000 0001",
               busy, done, overflow, {digit3, digit2, digit1, digit0}, mode);
    end
    #2;
    rst = 1'b1;
    pulses = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    tests++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL reset_mid_no_done: got pulses=%0d expected 0", pulses);
    end
    run_conv(14'd88, lat);
    tests++;
    if ({digit3, digit2, digit1, digit0} !== 16'h0088 || lat != 14) begin
      fails++;
      $display("FAIL reset_mid_restart: got %h lat=%0d expected 0088 lat=14",
               {digit3, digit2, digit1, digit0}, lat);
    end
  endtask

  task automatic test_back_to_back;
    int first, second;
    first  = -1;
    second = -1;
    @(posedge clk); #1;
    start = 1'b1;
    bin   = 14'd300;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (done) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
    start = 1'b0;
    tests++;
    if (first < 0 || second < 0 || (second - first) != 16) begin
      fails++;
      $display("FAIL back_to_back_period: got first=%0d second=%0d expected spacing 16", first, second);
    end
    tests++;
    if ({digit3, digit2, digit1, digit0, mode} !== {16'h0300, 4'b0111}) begin
      fails++;
      $display("FAIL back_to_back_result: got %h mode=%b expected 0300 mode=0111",
               {digit3, digit2, digit1, digit0}, mode);
    end
    repeat (20) @(posedge clk);
  endtask

  task automatic test_sweep;
    int vals[$];
    int lat;
    logic [15:0] exp_d;
    vals = '{0, 9, 10, 99, 100, 999, 1000, 4095, 9999, 10000, 16383};
    for (int i = 0; i < 24; i++) vals.push_back(int'($urandom_range(0, 16383)));
    foreach (vals[i]) begin
      run_conv(14'(vals[i]), lat);
      exp_d = ref_digits(vals[i]);
      tests++;
      if ({digit3, digit2, digit1, digit0, mode, overflow} !== {exp_d, ref_mode(exp_d), vals[i] > 9999} ||
          lat != 14) begin
        fails++;
        $display("FAIL sweep_%0d: got %h mode=%b ovf=%b lat=%0d expected %h mode=%b ovf=%b lat=14",
                 vals[i], {digit3, digit2, digit1, digit0}, mode, overflow, lat,
                 exp_d, ref_mode(exp_d), vals[i] > 9999);
      end
      tests++;
      if ({nb_digit3, nb_digit2, nb_digit1, nb_digit0, nb_mode} !== {exp_d, 4'b1111}) begin
        fails++;
        $display("FAIL sweep_nb_%0d: got %h mode=%b expected %h mode=1111",
                 vals[i], {nb_digit3, nb_digit2, nb_digit1, nb_digit0}, nb_mode, exp_d);
      end
    end
  endtask

  initial begin
    test_reset;
    test_zero;
    test_digits;
    test_overflow;
    test_blank_off;
    test_ignore_start;
    test_reset_mid;
    test_back_to_back;
    test_sweep;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
